alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one 32-bit integer ALU (add, sub, and, or, sll, sra) between two requesters, for example the execute stage and the branch/compare unit.
- Arbitration is round-robin.
- Operands are accepted through per-requester valid/ready handshakes.
- The ALU result is registered into a single response slot, tagged with the winning requester's id, and held until the consumer accepts it.

Parameters:
- DATA_WIDTH, 32, operand/result width. Only 32 is supported.
- OP_WIDTH, 5, ALU opcode width.
- SHAMT_WIDTH, 5, shift-amount width.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  OP_WIDTH  requester 0 opcode.
- req0_a  in  DATA_WIDTH  requester 0 operand A.
- req0_b  in  DATA_WIDTH  requester 0 operand B.
- req0_shamt  in  SHAMT_WIDTH  requester 0 shift amount.
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_shamt: same as requester 0, for requester 1.
- rsp_valid  out  1  response slot full.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that issued the response.
- rsp_data  out  DATA_WIDTH  ALU result.
- rsp_ovf  out  1  signed overflow (ADD/SUB only, else 0).
- rsp_ne  out  1  A != B (SUB only, else 0).
- rsp_lt  out  1  signed A < B (SUB only, else 0).

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high; all state changes on the rising edge of clock.
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_ovf=0, rsp_ne=0, rsp_lt=0, last_grant=1.
- Stall condition: stall = rsp_valid && !rsp_ready.
- Grants are combinational and forced to 0 during reset or stall. Otherwise:
  - Only req0_valid set: grant 0.
  - Only req1_valid set: grant 1.
  - Both set: grant the requester other than last_grant.
- req0_ready = grant0 and req1_ready = grant1. At most one ready is asserted per cycle. Ready never depends on the requester's own operand values.
- Requesters hold op, a, b and shamt stable while valid && !ready. Valid may drop only after acceptance.
- On acceptance (the grant edge):
  - last_grant <= the granted id.
  - The response slot loads the ALU result of the granted operands.
  - rsp_valid <= 1.
  - rsp_id <= the granted id.
- Latency: exactly 1 cycle from the acceptance edge to rsp_valid. Throughput is one operation per cycle while rsp_ready stays high (slot dequeue and load happen on the same edge).
- No grant, rsp_ready=1: rsp_valid <= 0; the data fields keep their last values.
- Stall: all rsp_* outputs hold; last_grant holds.
- Opcodes:
  - 00000 ADD
  - 00001 SUB
  - 00010 AND
  - 00011 OR
  - 00100 SLL by shamt
  - 00101 SRA by shamt (arithmetic)
  - Any other opcode: result 0, flags 0, still accepted and responded to.
- Arithmetic is mod 2^32.
- ovf = (A[31]==B'[31]) && (R[31]!=A[31]), where B' is B for ADD and ~B for SUB.
- lt = R[31] xor ovf for SUB.
- Reset while busy: the in-flight response is discarded, rsp_valid=0 on the next edge, and no ready is asserted during the reset cycle.

Optional Feature:
- Macro: ALU_ARB_PERF_EN.
- When defined, three extra outputs are added:
  - perf_grant0 (32): counts acceptances for requester 0.
  - perf_grant1 (32): counts acceptances for requester 1.
  - perf_conflict (32): counts cycles where both valids are high and there is no stall.
- All counters reset to 0, wrap at 2^32, and do not affect arbitration.
- When undefined, these ports and counters do not exist, and the remaining behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRA.
  - DATA_WIDTH.
  - A response struct typedef (data, ovf, ne, lt).
- One natural sub-module: alu_core, purely combinational. It takes op, a, b and shamt and produces data, ovf, ne and lt. The arbiter instantiates it once, on the muxed granted operands.

Test Plan:
- After reset, req0 ADD a=7,b=5 only, rsp_ready=1 -> req0_ready=1 in the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=12, flags 0.
- Both valid every cycle (req0 AND 0xF0F0F0F0,0xFF00FF00; req1 OR 0x1,0x2), rsp_ready=1 -> grants alternate 0,1,0,1 (req0 first after reset); responses 0xF000F000 and 0x3 back-to-back with no bubbles.
- rsp_ready=0 for 3 cycles with response pending and both requesters valid -> both readys 0, all rsp_* held stable, last_grant unchanged; on rsp_ready=1 the next grant goes to the requester not served last.
- req1 SUB a=0x7FFFFFFF,b=0xFFFFFFFF -> rsp_data=0x80000000, rsp_ovf=1, rsp_ne=1, rsp_lt=0. SRA a=0x80000000, shamt=4 -> 0xF8000000. Opcode 11111 -> rsp_data=0, flags 0.
- Reset asserted the cycle after a grant -> rsp_valid=0 after the reset edge, no ready during reset, last_grant=1; first post-reset conflict grants req0.
- With ALU_ARB_PERF_EN defined: 10 conflict cycles with no stall -> perf_grant0=5, perf_grant1=5, perf_conflict=10; reset clears all three.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: widths, opcodes, response struct.
package alu_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int OP_WIDTH    = 5;
  localparam int SHAMT_WIDTH = 5;

  localparam logic [OP_WIDTH-1:0] OP_ADD = 5'b00000;
  localparam logic [OP_WIDTH-1:0] OP_SUB = 5'b00001;
  localparam logic [OP_WIDTH-1:0] OP_AND = 5'b00010;
  localparam logic [OP_WIDTH-1:0] OP_OR  = 5'b00011;
  localparam logic [OP_WIDTH-1:0] OP_SLL = 5'b00100;
  localparam logic [OP_WIDTH-1:0] OP_SRA = 5'b00101;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  ovf;
    logic                  ne;
    logic                  lt;
  } alu_rsp_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two requesters, the consumer and the arbiter.
// master: requester/consumer side; slave: arbiter side.
interface alu_share_arbiter_if #(
  parameter int DATA_WIDTH  = alu_pkg::DATA_WIDTH,
  parameter int OP_WIDTH    = alu_pkg::OP_WIDTH,
  parameter int SHAMT_WIDTH = alu_pkg::SHAMT_WIDTH
);

  logic                   req0_valid;
  logic                   req0_ready;
  logic [OP_WIDTH-1:0]    req0_op;
  logic [DATA_WIDTH-1:0]  req0_a;
  logic [DATA_WIDTH-1:0]  req0_b;
  logic [SHAMT_WIDTH-1:0] req0_shamt;

  logic                   req1_valid;
  logic                   req1_ready;
  logic [OP_WIDTH-1:0]    req1_op;
  logic [DATA_WIDTH-1:0]  req1_a;
  logic [DATA_WIDTH-1:0]  req1_b;
  logic [SHAMT_WIDTH-1:0] req1_shamt;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_id;
  logic [DATA_WIDTH-1:0]  rsp_data;
  logic                   rsp_ovf;
  logic                   rsp_ne;
  logic                   rsp_lt;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_shamt,
    output req1_valid, req1_op, req1_a, req1_b, req1_shamt,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_ovf, rsp_ne, rsp_lt
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_shamt,
    input  req1_valid, req1_op, req1_a, req1_b, req1_shamt,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_ovf, rsp_ne, rsp_lt
  );

endinterface

// File: rtl/alu_core.sv
// Combinational 32-bit integer ALU: add, sub, and, or, sll, sra.
// Flags: ovf on ADD/SUB, ne/lt on SUB only; unknown opcodes yield all zeros.
module alu_core import alu_pkg::*; (
  input  logic [OP_WIDTH-1:0]    op,
  input  logic [DATA_WIDTH-1:0]  a,
  input  logic [DATA_WIDTH-1:0]  b,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output alu_rsp_t               res
);

  logic signed [DATA_WIDTH-1:0] a_s;
  logic signed [DATA_WIDTH-1:0] b_s;
  logic signed [DATA_WIDTH-1:0] sum_s;
  logic signed [DATA_WIDTH-1:0] diff_s;
  logic signed [DATA_WIDTH-1:0] sra_s;

  // Signed overflow: operands of equal sign giving a result of the other sign.
  function automatic logic ovf_f(input logic a_msb, input logic bx_msb, input logic r_msb);
    return (a_msb == bx_msb) && (r_msb != a_msb);
  endfunction

  assign a_s    = a;
  assign b_s    = b;
  assign sum_s  = a_s + b_s;
  assign diff_s = a_s - b_s;
  assign sra_s  = a_s >>> shamt;

  // Opcode decode with all outputs zeroed first.
  always_comb begin
    res = '0;
    case (op)
      OP_ADD: begin
        res.data = sum_s;
        res.ovf  = ovf_f(a[DATA_WIDTH-1], b[DATA_WIDTH-1], sum_s[DATA_WIDTH-1]);
      end
      OP_SUB: begin
        res.data = diff_s;
        res.ovf  = ovf_f(a[DATA_WIDTH-1], ~b[DATA_WIDTH-1], diff_s[DATA_WIDTH-1]);
        res.ne   = (a != b);
        res.lt   = diff_s[DATA_WIDTH-1] ^ res.ovf;
      end
      OP_AND:  res.data = a & b;
      OP_OR:   res.data = a | b;
      OP_SLL:  res.data = a << shamt;
      OP_SRA:  res.data = sra_s;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two requesters with a single
// registered response slot held until the consumer accepts it.
// Optional performance counters are built when ALU_ARB_PERF_EN is defined.
module alu_share_arbiter #(
  parameter int DATA_WIDTH  = alu_pkg::DATA_WIDTH,
  parameter int OP_WIDTH    = alu_pkg::OP_WIDTH,
  parameter int SHAMT_WIDTH = alu_pkg::SHAMT_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  alu_share_arbiter_if.slave bus
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]        perf_grant0,
  output logic [31:0]        perf_grant1,
  output logic [31:0]        perf_conflict
`endif
);

  logic                   stall;
  logic                   conflict;
  logic                   grant0;
  logic                   grant1;
  logic                   accept;
  logic [OP_WIDTH-1:0]    sel_op;
  logic [DATA_WIDTH-1:0]  sel_a;
  logic [DATA_WIDTH-1:0]  sel_b;
  logic [SHAMT_WIDTH-1:0] sel_shamt;
  alu_pkg::alu_rsp_t      alu_res;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic              last_grant_q, last_grant_d;
  alu_pkg::alu_rsp_t rsp_q, rsp_d;

  assign stall    = rsp_valid_q && !bus.rsp_ready;
  assign conflict = bus.req0_valid && bus.req1_valid;
  assign accept   = grant0 || grant1;

  // Round-robin grant; nothing is granted while in reset or stalled.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset && !stall) begin
      if (conflict) begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else if (bus.req0_valid) begin
        grant0 = 1'b1;
      end else if (bus.req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // Operand mux feeding the single shared ALU.
  always_comb begin
    sel_op    = bus.req0_op;
    sel_a     = bus.req0_a;
    sel_b     = bus.req0_b;
    sel_shamt = bus.req0_shamt;
    if (grant1) begin
      sel_op    = bus.req1_op;
      sel_a     = bus.req1_a;
      sel_b     = bus.req1_b;
      sel_shamt = bus.req1_shamt;
    end
  end

  alu_core u_alu_core (
    .op    (sel_op),
    .a     (sel_a),
    .b     (sel_b),
    .shamt (sel_shamt),
    .res   (alu_res)
  );

  // Response slot: load on accept, empty when drained, hold on stall.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_d        = rsp_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = grant1;
      rsp_d        = alu_res;
      last_grant_d = grant1;
    end else if (!stall) begin
      rsp_valid_d  = 1'b0;
    end
  end

  // Slot and round-robin pointer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_q        <= '0;
      last_grant_q <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_q        <= rsp_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_q.data;
  assign bus.rsp_ovf   = rsp_q.ovf;
  assign bus.rsp_ne    = rsp_q.ne;
  assign bus.rsp_lt    = rsp_q.lt;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_grant0_q, perf_grant0_d;
  logic [31:0] perf_grant1_q, perf_grant1_d;
  logic [31:0] perf_conflict_q, perf_conflict_d;

  // Free-running wrap-around event counters; observe only.
  always_comb begin
    perf_grant0_d   = perf_grant0_q + {31'd0, grant0};
    perf_grant1_d   = perf_grant1_q + {31'd0, grant1};
    perf_conflict_d = perf_conflict_q + {31'd0, (conflict && !stall)};
  end

  // Counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_grant0_q   <= '0;
      perf_grant1_q   <= '0;
      perf_conflict_q <= '0;
    end else begin
      perf_grant0_q   <= perf_grant0_d;
      perf_grant1_q   <= perf_grant1_d;
      perf_conflict_q <= perf_conflict_d;
    end
  end

  assign perf_grant0   = perf_grant0_q;
  assign perf_grant1   = perf_grant1_q;
  assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed testbench for alu_share_arbiter (perf counters checked when
// ALU_ARB_PERF_EN is defined).
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clock = ~clock;

  alu_share_arbiter_if bus ();

`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_grant0, perf_grant1, perf_conflict;
`endif

  alu_share_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_grant0   (perf_grant0),
    .perf_grant1   (perf_grant1),
    .perf_conflict (perf_conflict)
`endif
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.rsp_ready  = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_shamt = '0;
    bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_shamt = '0;
    cyc(); cyc();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    tests_run++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_ready got %b want 00", {bus.req0_ready, bus.req1_ready});
    end
    cyc();
    tests_run++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_ovf, bus.rsp_ne, bus.rsp_lt} !== 37'd0) begin
      tests_failed++;
      $display("FAIL reset_rsp got v=%b id=%b d=%h f=%b%b%b want all 0", bus.rsp_valid, bus.rsp_id,
               bus.rsp_data, bus.rsp_ovf, bus.rsp_ne, bus.rsp_lt);
    end
    reset = 1'b0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
  endtask

  task automatic test_single_add();
    bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 32'd7; bus.req0_b = 32'd5;
    #1;
    tests_run++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL add_ready got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    cyc();
    bus.req0_valid = 1'b0;
    tests_run++;
    if ({bus.rsp_valid, bus.rsp_id} !== 2'b10) begin
      tests_failed++;
      $display("FAIL add_valid_id got %b want 10", {bus.rsp_valid, bus.rsp_id});
    end
    tests_run++;
    if ({bus.rsp_data, bus.rsp_ovf, bus.rsp_ne, bus.rsp_lt} !== {32'd12, 3'b000}) begin
      tests_failed++;
      $display("FAIL add_data got %h/%b%b%b want 0000000c/000", bus.rsp_data, bus.rsp_ovf,
               bus.rsp_ne, bus.rsp_lt);
    end
    cyc();
    tests_run++;
    if ({bus.rsp_valid, bus.rsp_data} !== {1'b0, 32'd12}) begin
      tests_failed++;
      $display("FAIL add_drain got v=%b d=%h want v=0 d=0000000c", bus.rsp_valid, bus.rsp_data);
    end
  endtask

  task automatic test_back_to_back();
    logic        exp_id;
    logic [31:0] exp_d;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = OP_AND; bus.req0_a = 32'hF0F0F0F0; bus.req0_b = 32'hFF00FF00;
    bus.req1_valid = 1'b1; bus.req1_op = OP_OR;  bus.req1_a = 32'h1;        bus.req1_b = 32'h2;
    bus.req0_shamt = '0; bus.req1_shamt = '0;
    for (int i = 0; i < 4; i++) begin
      exp_id = (i % 2) != 0;
      exp_d  = exp_id ? 32'h3 : 32'hF000F000;
      #1;
      tests_run++;
      if ({bus.req0_ready, bus.req1_ready} !== {!exp_id, exp_id}) begin
        tests_failed++;
        $display("FAIL b2b_grant[%0d] got %b want %b", i, {bus.req0_ready, bus.req1_ready}, {!exp_id, exp_id});
      end
      cyc();
      tests_run++;
      if ({bus.rsp_valid, bus.rsp_id} !== {1'b1, exp_id}) begin
        tests_failed++;
        $display("FAIL b2b_valid_id[%0d] got %b want %b", i, {bus.rsp_valid, bus.rsp_id}, {1'b1, exp_id});
      end
      tests_run++;
      if (bus.rsp_data !== exp_d) begin
        tests_failed++;
        $display("FAIL b2b_data[%0d] got %h want %h", i, bus.rsp_data, exp_d);
      end
    end
  endtask

  task automatic test_stall();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
        tests_failed++;
        $display("FAIL stall_ready[%0d] got %b want 00", i, {bus.req0_ready, bus.req1_ready});
      end
      cyc();
      tests_run++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_ovf, bus.rsp_ne, bus.rsp_lt} !==
          {1'b1, 1'b1, 32'h3, 3'b000}) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d] got v=%b id=%b d=%h f=%b%b%b want v=1 id=1 d=00000003 f=000", i,
                 bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_ovf, bus.rsp_ne, bus.rsp_lt);
      end
    end
    bus.rsp_ready = 1'b1;
    #1;
    tests_run++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL stall_release_grant got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    cyc();
    tests_run++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, 1'b0, 32'hF000F000}) begin
      tests_failed++;
      $display("FAIL stall_release_rsp got v=%b id=%b d=%h want v=1 id=0 d=f000f000", bus.rsp_valid,
               bus.rsp_id, bus.rsp_data);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    cyc();
  endtask

  task automatic test_ops();
    logic [4:0]  v_op [9];
    logic [31:0] v_a  [9];
    logic [31:0] v_b  [9];
    logic [4:0]  v_sh [9];
    logic [31:0] v_d  [9];
    logic [2:0]  v_f  [9];
    logic        id;
    v_op[0] = OP_SUB;   v_a[0] = 32'h7FFFFFFF; v_b[0] = 32'hFFFFFFFF; v_sh[0] = 5'd0;  v_d[0] = 32'h80000000; v_f[0] = 3'b110;
    v_op[1] = OP_SRA;   v_a[1] = 32'h80000000; v_b[1] = 32'h0;        v_sh[1] = 5'd4;  v_d[1] = 32'hF8000000; v_f[1] = 3'b000;
    v_op[2] = 5'b11111; v_a[2] = 32'h123;      v_b[2] = 32'h456;      v_sh[2] = 5'd3;  v_d[2] = 32'h0;        v_f[2] = 3'b000;
    v_op[3] = OP_ADD;   v_a[3] = 32'h7FFFFFFF; v_b[3] = 32'h1;        v_sh[3] = 5'd0;  v_d[3] = 32'h80000000; v_f[3] = 3'b100;
    v_op[4] = OP_SUB;   v_a[4] = 32'd3;        v_b[4] = 32'd5;        v_sh[4] = 5'd0;  v_d[4] = 32'hFFFFFFFE; v_f[4] = 3'b011;
    v_op[5] = OP_SUB;   v_a[5] = 32'd5;        v_b[5] = 32'd5;        v_sh[5] = 5'd0;  v_d[5] = 32'h0;        v_f[5] = 3'b000;
    v_op[6] = OP_SLL;   v_a[6] = 32'h3;        v_b[6] = 32'hFFFF;     v_sh[6] = 5'd4;  v_d[6] = 32'h30;       v_f[6] = 3'b000;
    v_op[7] = OP_AND;   v_a[7] = 32'hFFFF0000; v_b[7] = 32'h0F0F0F0F; v_sh[7] = 5'd0;  v_d[7] = 32'h0F0F0000; v_f[7] = 3'b000;
    v_op[8] = OP_SRA;   v_a[8] = 32'h40000000; v_b[8] = 32'h0;        v_sh[8] = 5'd30; v_d[8] = 32'h1;        v_f[8] = 3'b000;
    for (int i = 0; i < 9; i++) begin
      id = (i % 2) != 0;
      bus.req0_valid = !id; bus.req1_valid = id;
      bus.req0_op = v_op[i]; bus.req0_a = v_a[i]; bus.req0_b = v_b[i]; bus.req0_shamt = v_sh[i];
      bus.req1_op = v_op[i]; bus.req1_a = v_a[i]; bus.req1_b = v_b[i]; bus.req1_shamt = v_sh[i];
      #1;
      tests_run++;
      if ({bus.req0_ready, bus.req1_ready} !== {!id, id}) begin
        tests_failed++;
        $display("FAIL ops_grant[%0d] got %b want %b", i, {bus.req0_ready, bus.req1_ready}, {!id, id});
      end
      cyc();
      tests_run++;
      if ({bus.rsp_valid, bus.rsp_id} !== {1'b1, id}) begin
        tests_failed++;
        $display("FAIL ops_valid_id[%0d] got %b want %b", i, {bus.rsp_valid, bus.rsp_id}, {1'b1, id});
      end
      tests_run++;
      if ({bus.rsp_data, bus.rsp_ovf, bus.rsp_ne, bus.rsp_lt} !== {v_d[i], v_f[i]}) begin
        tests_failed++;
        $display("FAIL ops_result[%0d] got %h/%b%b%b want %h/%b", i, bus.rsp_data, bus.rsp_ovf,
                 bus.rsp_ne, bus.rsp_lt, v_d[i], v_f[i]);
      end
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    cyc();
  endtask

  task automatic test_reset_busy();
    bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 32'd1; bus.req0_b = 32'd2;
    bus.req1_op = OP_OR; bus.req1_a = 32'h10; bus.req1_b = 32'h20;
    #1;
    tests_run++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL rbusy_grant got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    cyc();
    reset = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    tests_run++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      tests_failed++;
      $display("FAIL rbusy_ready_in_reset got %b want 00", {bus.req0_ready, bus.req1_ready});
    end
    cyc();
    reset = 1'b0;
    tests_run++;
    if ({bus.rsp_valid, bus.rsp_data} !== 33'd0) begin
      tests_failed++;
      $display("FAIL rbusy_discard got v=%b d=%h want v=0 d=00000000", bus.rsp_valid, bus.rsp_data);
    end
    #1;
    tests_run++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL rbusy_first_conflict got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    cyc();
    tests_run++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, 1'b0, 32'd3}) begin
      tests_failed++;
      $display("FAIL rbusy_rsp got v=%b id=%b d=%h want v=1 id=0 d=00000003", bus.rsp_valid,
               bus.rsp_id, bus.rsp_data);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    cyc();
  endtask

`ifdef ALU_ARB_PERF_EN
  task automatic test_perf();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    tests_run++;
    if ({perf_grant0, perf_grant1, perf_conflict} !== 96'd0) begin
      tests_failed++;
      $display("FAIL perf_after_reset got %0d/%0d/%0d want 0/0/0", perf_grant0, perf_grant1, perf_conflict);
    end
    bus.rsp_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    repeat (10) cyc();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    tests_run++;
    if ({perf_grant0, perf_grant1, perf_conflict} !== {32'd5, 32'd5, 32'd10}) begin
      tests_failed++;
      $display("FAIL perf_counts got %0d/%0d/%0d want 5/5/10", perf_grant0, perf_grant1, perf_conflict);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    tests_run++;
    if ({perf_grant0, perf_grant1, perf_conflict} !== 96'd0) begin
      tests_failed++;
      $display("FAIL perf_clear got %0d/%0d/%0d want 0/0/0", perf_grant0, perf_grant1, perf_conflict);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_stall();
    test_ops();
    test_reset_busy();
`ifdef ALU_ARB_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
